// File: rtl/seq_det_pkg.sv
// seq_det_pkg: state encoding and configuration defaults shared by the sequence detector
package seq_det_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  localparam int LEN_W = 4;
  localparam logic [7:0] DEF_PAT = 8'b0001_0101;
  localparam logic [LEN_W-1:0] DEF_LEN = 4'd5;
  localparam int DEF_THRESH = 0;
endpackage

// File: rtl/pattern_match_core.sv
// pattern_match_core: bit history, fill tracking and length-masked overlapping pattern compare
module pattern_match_core
  import seq_det_pkg::*;
#(
  parameter int PAT_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic [PAT_MAX-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);
  localparam int FILL_W = $clog2(PAT_MAX + 1);
  logic [PAT_MAX-1:0] hist, hist_new, mask;
  logic [FILL_W-1:0] fill, fill_new;
  logic hit;
  always_comb begin
    hist_new = {hist[PAT_MAX-2:0], bit_in};
    fill_new = (fill == FILL_W'(PAT_MAX)) ? fill : fill + 1'b1;
    for (int i = 0; i < PAT_MAX; i++) mask[i] = 32'(i) < 32'(len);
    hit = bit_valid && len != '0 && 32'(fill_new) >= 32'(len) && (hist_new & mask) == (pat & mask);
  end
  // history survives a match so overlapping occurrences are still seen
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (clr) begin
        hist <= '0;
        fill <= '0;
      end else if (bit_valid) begin
        hist <= hist_new;
        fill <= fill_new;
      end
    end
endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: word-to-bit sequencer feeding an overlapping pattern detector
// with a saturating match counter and sticky threshold flag
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               cnt_clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               thresh_hit,
  output logic               busy
);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  state_t state, state_nxt;
  logic [DATA_W-1:0] word;
  logic [IDX_W-1:0] bit_idx;
  logic [PAT_MAX-1:0] pat;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] thresh, cnt_nxt;
  logic hs, cfg_ok, last;
  // the final bit of a word doubles as an accept slot for zero-bubble streaming
  always_comb begin
    last      = bit_idx == '0;
    in_ready  = state == IDLE || last;
    hs        = in_valid && in_ready;
    cfg_ok    = cfg_we && state == IDLE && !hs;
    state_nxt = hs ? SHIFT : (state == SHIFT && !last) ? SHIFT : IDLE;
    bit_valid = state == SHIFT;
    bit_out   = bit_valid && word[bit_idx];
    busy      = state != IDLE;
    cnt_nxt   = (match && match_cnt != '1) ? match_cnt + 1'b1 : match_cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      word       <= '0;
      bit_idx    <= '0;
      pat        <= PAT_MAX'(DEF_PAT);
      len        <= DEF_LEN;
      thresh     <= CNT_W'(DEF_THRESH);
      match_cnt  <= '0;
      thresh_hit <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        word    <= in_data;
        bit_idx <= IDX_W'(DATA_W - 1);
      end else if (bit_valid && !last) begin
        bit_idx <= bit_idx - 1'b1;
      end
      if (cfg_ok) begin
        pat    <= cfg_pat;
        len    <= (32'(cfg_len) > PAT_MAX) ? LEN_W'(PAT_MAX) : cfg_len;
        thresh <= cfg_thresh;
      end
      if (cnt_clr || cfg_ok) begin
        match_cnt  <= '0;
        thresh_hit <= 1'b0;
      end else begin
        match_cnt  <= cnt_nxt;
        thresh_hit <= thresh_hit || (thresh != '0 && cnt_nxt >= thresh);
      end
    end
  pattern_match_core #(.PAT_MAX(PAT_MAX)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cfg_ok),
    .bit_valid(bit_valid),
    .bit_in   (bit_out),
    .pat      (pat),
    .len      (len),
    .match    (match)
  );
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: scoreboard bench; stimulus queues expected bits/matches, a negedge monitor checks them
module tb_seq_det_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, cnt_clr = 1'b0, in_valid = 1'b0;
  logic [7:0] cfg_pat = '0, in_data = '0;
  logic [3:0] cfg_len = '0;
  logic [2:0] cfg_thresh = '0;
  logic in_ready, bit_out, bit_valid, match, thresh_hit, busy;
  logic [2:0] match_cnt;
  typedef struct {logic b; logic m; logic last;} exp_t;
  exp_t q[$];
  exp_t e;
  int errors = 0, checks = 0, exp_rise = 0, run = 0, max_run = 0;
  logic pend = 1'b0, th_prev = 1'b0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_thresh(cfg_thresh), .cnt_clr(cnt_clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bit_out(bit_out), .bit_valid(bit_valid), .match(match),
    .match_cnt(match_cnt), .thresh_hit(thresh_hit), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic [7:0] mf);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hs_ready", 32'(in_ready), 1);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    for (int i = 7; i >= 0; i--) q.push_back('{d[i], mf[i], i == 0});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 40);
    chk("idle_reached", 32'(busy), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      pend = 1'b0;
      run = 0;
      th_prev = 1'b0;
    end else begin
      chk("match", 32'(match), 32'(pend));
      pend = 1'b0;
      if (bit_valid) begin
        run++;
        if (run > max_run) max_run = run;
        chk("queue_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("bit_out", 32'(bit_out), 32'(e.b));
          chk("in_ready_shift", 32'(in_ready), 32'(e.last));
          pend = e.m;
        end
      end else begin
        run = 0;
        chk("in_ready_idle", 32'(in_ready), 1);
      end
      if (thresh_hit && !th_prev) chk("thresh_rise_cnt", 32'(match_cnt), 32'(exp_rise));
      th_prev = thresh_hit;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bit_valid", 32'(bit_valid), 0);
    chk("rst_bit_out", 32'(bit_out), 0);
    chk("rst_match", 32'(match), 0);
    chk("rst_cnt", 32'(match_cnt), 0);
    chk("rst_thresh", 32'(thresh_hit), 0);
    rst_n = 1'b1;
    tick();
    // defaults: 10101 len 5, matches after bits 5 and 7
    send_word(8'hAA, 8'b0000_1010);
    wait_idle();
    tick();
    chk("t1_cnt", 32'(match_cnt), 2);
    chk("t1_thresh", 32'(thresh_hit), 0);
    // back-to-back words, history continues from the previous word
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t2_clr_cnt", 32'(match_cnt), 0);
    max_run = 0;
    send_word(8'hAA, 8'b1010_1010);
    send_word(8'h00, 8'b0000_0000);
    send_word(8'hAA, 8'b0000_1010);
    wait_idle();
    tick();
    chk("t2_run", 32'(max_run), 24);
    chk("t2_cnt", 32'(match_cnt), 6);
    // match spanning a word boundary
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    send_word(8'h05, 8'b0000_0000);
    wait_idle();
    repeat (3) tick();
    send_word(8'h40, 8'b0100_0000);
    wait_idle();
    tick();
    chk("t3_cnt", 32'(match_cnt), 1);
    // reconfigure in IDLE, then an ignored write mid-word
    exp_rise = 3;
    cfg_pat = 8'h03;
    cfg_len = 4'd2;
    cfg_thresh = 3'd3;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk("t4_cfg_clr_cnt", 32'(match_cnt), 0);
    send_word(8'hFF, 8'b0111_1111);
    cfg_pat = 8'h00;
    cfg_len = 4'd1;
    cfg_thresh = 3'd1;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    wait_idle();
    tick();
    chk("t4_cnt", 32'(match_cnt), 7);
    chk("t4_thresh", 32'(thresh_hit), 1);
    // saturation, then clear coincident with the final match pulse
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t5_clr_cnt", 32'(match_cnt), 0);
    chk("t5_clr_thresh", 32'(thresh_hit), 0);
    send_word(8'hFF, 8'hFF);
    send_word(8'hFF, 8'hFF);
    repeat (4) tick();
    chk("t5_sat", 32'(match_cnt), 7);
    wait_idle();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t5_clr_on_match_cnt", 32'(match_cnt), 0);
    chk("t5_clr_on_match_thresh", 32'(thresh_hit), 0);
    // asynchronous reset during the 4th bit
    send_word(8'hAA, 8'b1000_0000);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_bit_valid", 32'(bit_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_in_ready", 32'(in_ready), 1);
    chk("t6_match", 32'(match), 0);
    chk("t6_cnt", 32'(match_cnt), 0);
    chk("t6_thresh", 32'(thresh_hit), 0);
    exp_rise = 0;
    tick();
    rst_n = 1'b1;
    tick();
    send_word(8'hAA, 8'b0000_1010);
    wait_idle();
    tick();
    chk("t6_post_cnt", 32'(match_cnt), 2);
    chk("t6_post_thresh", 32'(thresh_hit), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
